// File: rtl/alu_shift_seq.sv
// CB-prefix shift/rotate micro-sequencer: drives the ALU control lines through a
// load/shift cycle and a result cycle, then reports the new C/Z flags with a done pulse.
module alu_shift_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] cb_op,
  input  logic [7:0] operand,
  input  logic       carry_in,
  input  logic       shift_dbh,
  input  logic       zero,
  output logic [7:0] alu_op,
  output logic       alu_si,
  output logic [1:0] alu_sh,
  output logic [1:0] alu_oe,
  output logic       alu_la,
  output logic       alu_lb,
  output logic       alu_r,
  output logic       alu_s,
  output logic       alu_v,
  output logic       alu_ne,
  output logic       alu_ci,
  output logic       alu_l,
  output logic       alu_h,
  output logic       busy,
  output logic       done,
  output logic       flag_c,
  output logic       flag_z,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RESULT = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [1:0] NO_SH  = 2'b00;
  localparam logic [1:0] L_SH   = 2'b01;
  localparam logic [1:0] R_SH   = 2'b10;
  localparam logic [1:0] SH_OE  = 2'b01;
  localparam logic [1:0] RES_OE = 2'b10;

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;

  // One complete ALU control word; the register holding it is the latched request.
  typedef struct packed {
    logic [7:0] op;
    logic       si;
    logic [1:0] sh;
    logic [1:0] oe;
    logic       la;
    logic       lb;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } ctrl_t;

  state_t state, state_next;
  ctrl_t  ctrl, ctrl_next;
  logic   pend_c, pend_c_next;
  logic   pend_z, pend_z_next;
  logic   done_next, illegal_next;
  logic   flag_c_next, flag_z_next;

  // Load/shift word: operand is loaded onto both ALU buses and shifted in the low phase.
  function automatic ctrl_t shift_word(input logic [2:0] op,
                                       input logic [7:0] b,
                                       input logic       cin);
    ctrl_t w;
    w    = '0;
    w.op = b;
    w.oe = SH_OE;
    w.la = 1'b1;
    w.lb = 1'b1;
    w.r  = 1'b1;
    w.s  = 1'b1;
    w.v  = 1'b1;
    w.l  = 1'b1;
    case (op)
      OP_RLC:  begin w.sh = L_SH; w.si = b[7]; end
      OP_RRC:  begin w.sh = R_SH; w.si = b[0]; end
      OP_RL:   begin w.sh = L_SH; w.si = cin;  end
      OP_RR:   begin w.sh = R_SH; w.si = cin;  end
      OP_SLA:  begin w.sh = L_SH; w.si = 1'b0; end
      OP_SRA:  begin w.sh = R_SH; w.si = b[7]; end
      default: begin w.sh = R_SH; w.si = 1'b0; end  // SRL; SWAP never gets here
    endcase
    return w;
  endfunction

  // Result word: operand and shift-in stay on the lines, result driven in the high phase.
  function automatic ctrl_t result_word(input ctrl_t prev);
    ctrl_t w;
    w    = '0;
    w.op = prev.op;
    w.si = prev.si;
    w.sh = NO_SH;
    w.oe = RES_OE;
    w.r  = 1'b1;
    w.s  = 1'b1;
    w.v  = 1'b1;
    w.h  = 1'b1;
    return w;
  endfunction

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    ctrl_next    = '0;
    pend_c_next  = pend_c;
    pend_z_next  = pend_z;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    flag_c_next  = flag_c;
    flag_z_next  = flag_z;
    case (state)
      IDLE: begin
        if (start) begin
          if (cb_op == OP_SWAP) begin
            illegal_next = 1'b1;
          end else begin
            ctrl_next  = shift_word(cb_op, operand, carry_in);
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        pend_c_next = shift_dbh;
        ctrl_next   = result_word(ctrl);
        state_next  = RESULT;
      end
      RESULT: begin
        pend_z_next = zero;
        state_next  = FINISH;
      end
      FINISH: begin
        done_next   = 1'b1;
        flag_c_next = pend_c;
        flag_z_next = pend_z;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl    <= '0;
      pend_c  <= 1'b0;
      pend_z  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      ctrl    <= ctrl_next;
      pend_c  <= pend_c_next;
      pend_z  <= pend_z_next;
      done    <= done_next;
      illegal <= illegal_next;
      flag_c  <= flag_c_next;
      flag_z  <= flag_z_next;
    end
  end

  assign alu_op = ctrl.op;
  assign alu_si = ctrl.si;
  assign alu_sh = ctrl.sh;
  assign alu_oe = ctrl.oe;
  assign alu_la = ctrl.la;
  assign alu_lb = ctrl.lb;
  assign alu_r  = ctrl.r;
  assign alu_s  = ctrl.s;
  assign alu_v  = ctrl.v;
  assign alu_ne = ctrl.ne;
  assign alu_ci = ctrl.ci;
  assign alu_l  = ctrl.l;
  assign alu_h  = ctrl.h;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_shift_seq.sv
// Randomized scoreboard bench for alu_shift_seq: the driver pushes expected ALU words and
// flags from an arithmetic shift model; a monitor compares whatever the DUT presents.
module tb_alu_shift_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] cb_op;
  logic [7:0] operand;
  logic       carry_in;
  logic       shift_dbh;
  logic       zero;
  logic [7:0] alu_op;
  logic       alu_si;
  logic [1:0] alu_sh;
  logic [1:0] alu_oe;
  logic       alu_la, alu_lb, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
  logic       busy, done, flag_c, flag_z, illegal;

  alu_shift_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cb_op(cb_op), .operand(operand),
    .carry_in(carry_in), .shift_dbh(shift_dbh), .zero(zero),
    .alu_op(alu_op), .alu_si(alu_si), .alu_sh(alu_sh), .alu_oe(alu_oe),
    .alu_la(alu_la), .alu_lb(alu_lb), .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v),
    .alu_ne(alu_ne), .alu_ci(alu_ci), .alu_l(alu_l), .alu_h(alu_h),
    .busy(busy), .done(done), .flag_c(flag_c), .flag_z(flag_z), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] op;
    logic       si;
    logic [1:0] sh;
    logic       c;
    logic       z;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_on = 1'b0;
  logic exp_fc = 1'b0;
  logic exp_fz = 1'b0;
  logic cur_c  = 1'b0;
  logic cur_z  = 1'b0;

  // ALU stand-in: returns the expected bits only in the cycle they are valid, inverted otherwise.
  assign shift_dbh = (alu_oe == 2'b01) ? cur_c : ~cur_c;
  assign zero      = (alu_oe == 2'b10) ? cur_z : ~cur_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic result and carry; shift-in is the bit that fills the vacated end.
  function automatic exp_t model(input int op, input int a, input int cin);
    exp_t e;
    int   r, c;
    bit   left;
    case (op)
      0: begin r = ((a * 2) % 256) + a / 128;       c = a / 128; left = 1; end
      1: begin r = a / 2 + (a % 2) * 128;           c = a % 2;   left = 0; end
      2: begin r = ((a * 2) % 256) + cin;           c = a / 128; left = 1; end
      3: begin r = a / 2 + cin * 128;               c = a % 2;   left = 0; end
      4: begin r = (a * 2) % 256;                   c = a / 128; left = 1; end
      5: begin r = a / 2 + (a / 128) * 128;         c = a % 2;   left = 0; end
      default: begin r = a / 2;                     c = a % 2;   left = 0; end
    endcase
    e.op = 8'(a);
    e.si = left ? 1'(r % 2) : 1'(r / 128);
    e.sh = left ? 2'b01 : 2'b10;
    e.c  = 1'(c);
    e.z  = (r == 0);
    return e;
  endfunction

  // Monitor: compares control words, done/flags and flag hold against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (alu_oe == 2'b01 || alu_oe == 2'b10) begin
          if (q.size() == 0) begin
            check("unexpected_alu_word", 32'(alu_oe), 32'd0);
          end else begin
            check("alu_op", 32'(alu_op), 32'(q[0].op));
            check("alu_si", 32'(alu_si), 32'(q[0].si));
            check("busy_in_seq", 32'(busy), 32'd1);
            if (alu_oe == 2'b01) begin
              check("shift_sh", 32'(alu_sh), 32'(q[0].sh));
              check("shift_fields", 32'({alu_la, alu_lb, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h}),
                    32'(9'b11_111_00_10));
            end else begin
              check("result_sh", 32'(alu_sh), 32'd0);
              check("result_fields", 32'({alu_la, alu_lb, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h}),
                    32'(9'b00_111_00_01));
            end
          end
        end else if (alu_oe == 2'b00) begin
          check("alu_idle_zero", 32'({alu_op, alu_si, alu_sh, alu_la, alu_lb, alu_r, alu_s, alu_v,
                                      alu_ne, alu_ci, alu_l, alu_h}), 32'd0);
        end else begin
          check("alu_oe_code", 32'(alu_oe), 32'd0);
        end
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            exp_fc = e.c;
            exp_fz = e.z;
            check("busy_at_done", 32'(busy), 32'd0);
          end
        end
        check("flag_c", 32'(flag_c), 32'(exp_fc));
        check("flag_z", 32'(flag_z), 32'(exp_fz));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one legal op; optionally pokes start again mid-sequence. Returns in the done cycle.
  task automatic run_op(input int op, input int a, input int cin, input bit spurious);
    exp_t e;
    int   cnt;
    bit   got;
    e = model(op, a, cin);
    q.push_back(e);
    cur_c    = e.c;
    cur_z    = e.z;
    start    = 1'b1;
    cb_op    = 3'(op);
    operand  = 8'(a);
    carry_in = 1'(cin);
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt   = 0;
    got   = 0;
    while (cnt < 10 && !got) begin
      @(negedge clk);
      cnt++;
      if (done) got = 1;
      check("illegal_quiet", 32'(illegal), 32'd0);
      start    = (cnt == 1) ? spurious : 1'b0;
      cb_op    = 3'($urandom);
      operand  = 8'($urandom);
      carry_in = 1'($urandom);
    end
    start = 1'b0;
    check("latency", 32'(cnt), 32'd4);
  endtask

  task automatic run_illegal();
    start = 1'b1;
    cb_op = 3'd6;
    operand = 8'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("illegal_pulse", 32'({illegal, busy}), 32'b10);
    @(negedge clk);
    check("illegal_once", 32'({illegal, busy}), 32'b00);
  endtask

  task automatic run_reset_mid_shift();
    exp_t e;
    e = model(4, 8'h81, 0);
    q.push_back(e);
    cur_c = e.c;
    cur_z = e.z;
    start = 1'b1;
    cb_op = 3'd4;
    operand = 8'h81;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    start   = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    exp_fc = 1'b0;
    exp_fz = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_abort_outputs", 32'({busy, done, illegal, flag_c, flag_z, alu_oe}), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("reset_no_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    cb_op    = 3'd0;
    operand  = 8'd0;
    carry_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_alu", 32'({alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb, alu_r, alu_s, alu_v,
                            alu_ne, alu_ci, alu_l, alu_h}), 32'd0);
    check("reset_status", 32'({busy, done, illegal, flag_c, flag_z}), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_on  = 1'b1;
    idle(2);

    // Directed cases from the boundary list.
    run_op(4, 8'h81, 0, 0);  idle(1);
    run_op(3, 8'h01, 1, 0);  idle(1);
    run_op(5, 8'h80, 0, 0);  idle(1);
    run_op(1, 8'h01, 0, 0);  idle(1);
    run_op(7, 8'h01, 0, 0);  idle(1);
    run_illegal();           idle(1);
    run_op(2, 8'hff, 1, 1);  idle(1);
    run_op(0, 8'h00, 1, 0);
    run_op(7, 8'h80, 0, 0);
    run_op(2, 8'h7f, 0, 1);
    idle(1);
    run_reset_mid_shift();
    idle(1);

    // Randomized mix: back-to-back or gapped, spurious starts, occasional illegal op.
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) begin
        run_illegal();
      end else begin
        if (op == 6) op = 7;
        run_op(op, $urandom_range(0, 255), $urandom_range(0, 1), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(4);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Micro-sequencer on the driving end of the ALU control-line interface.
- Accepts a decoded CB-prefix shift/rotate request and emits the two ALU control words the ALU expects: a load/shift cycle, then a result cycle.
- Samples the ALU's shifted-out bit (shift_dbh) and zero output, and returns the new C/Z flags to the core with a done pulse.
- Sits between the instruction decoder and the ALU.

Parameters:
- NONE

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- cb_op  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP (illegal here), 7 SRL
- operand  in  8  value to shift, from the data bus
- carry_in  in  1  current C flag
- shift_dbh  in  1  ALU shifted-out bit; valid in SHIFT state
- zero  in  1  ALU zero output; valid in RESULT state
- alu_op  out  8  ALU operand field
- alu_si  out  1  shift-in bit
- alu_sh  out  2  00 NO_SH, 01 L_SH, 10 R_SH
- alu_oe  out  2  00 NO_OE, 01 SH_OE, 10 RES_OE
- alu_la  out  1  1 = BUS_LD, 0 = NO_LD
- alu_lb  out  1  1 = BUS_LD, 0 = NO_LD
- alu_r, alu_s, alu_v  out  1 each  ALU enables
- alu_ne, alu_ci  out  1 each  negate and carry-in
- alu_l, alu_h  out  1 each  low/high nibble phase
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when flags are valid
- flag_c, flag_z  out  1 each  resulting flags; hold until the next done
- illegal  out  1  one-cycle pulse when start arrives with cb_op == 6

Behaviour:
- States: IDLE, SHIFT, RESULT, FINISH.
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All alu_* outputs, busy, done, illegal, flag_c and flag_z are cleared to 0.
  - Reset mid-sequence aborts the sequence; no done is issued.
- IDLE:
  - alu_* outputs are all 0.
  - start with a legal cb_op: latch operand, cb_op and carry_in, then go to SHIFT.
  - start with cb_op == 6: pulse illegal next cycle and stay in IDLE.
- SHIFT (one cycle; alu_* outputs registered from the latched request):
  - alu_op = latched operand.
  - alu_sh = L_SH for RLC, RL, SLA; R_SH for RRC, RR, SRA, SRL.
  - alu_si per op: RLC b[7]; RRC b[0]; RL carry_in; RR carry_in; SLA 0; SRA b[7]; SRL 0.
  - Fixed fields: oe = SH_OE, la = lb = BUS_LD, r = s = v = 1, ne = ci = 0, l = 1, h = 0.
  - Capture shift_dbh into the pending carry, then go to RESULT.
- RESULT (one cycle):
  - Fixed fields: la = lb = NO_LD, oe = RES_OE, r = s = v = 1, ne = ci = 0, l = 0, h = 1.
  - alu_op and alu_si hold their SHIFT values; alu_sh = NO_SH.
  - Capture zero, then go to FINISH.
- FINISH (one cycle):
  - alu_* outputs are 0.
  - done = 1; flag_c = pending carry; flag_z = captured zero.
  - Go to IDLE.
- Latency: start to done is 4 cycles, with done asserted in cycle 4 after the start edge.
- Back-to-back operation: start may be asserted in the cycle after FINISH. start while busy is ignored and not queued.
- Latched inputs: operand, cb_op and carry_in changing after the start cycle have no effect on the sequence.
- flag_c and flag_z change only in FINISH.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles mid-SHIFT -> next cycle IDLE, all outputs 0, no done.
- SLA: start with cb_op = 4, operand = 0x81 -> SHIFT cycle shows alu_op = 0x81, alu_si = 0, alu_sh = 01, alu_oe = 01, la = lb = 1, l = 1. With the bench returning shift_dbh = 1 and zero = 0: done after 4 cycles, flag_c = 1, flag_z = 0.
- RR and SRA: RR with operand = 0x01, carry_in = 1 -> alu_si = 1, alu_sh = 10. SRA with operand = 0x80, carry_in = 0 -> alu_si = 1. RRC with operand = 0x01 -> alu_si = 1.
- SRL producing zero: operand = 0x01, the bench returns zero = 1 in RESULT -> flag_z = 1. The RESULT cycle shows oe = 10, la = lb = 0, h = 1, l = 0.
- Illegal and busy: start with cb_op = 6 -> illegal pulses once, busy stays 0. A second start asserted during SHIFT -> ignored, exactly one done.
- Back-to-back and input hold: start again the cycle after done -> new sequence runs correctly. Operand changed during SHIFT -> alu_op keeps the latched value.
